// File: rtl/stream_burst_source.sv
// Command-driven stream source: emits start, start+stride, ... for count beats with optional idle gaps.
// Outputs are registered; data, valid and last hold until the downstream handshake.
module stream_burst_source #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int GAP_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DATA_WIDTH-1:0]  cmd_start,
  input  logic [DATA_WIDTH-1:0]  cmd_stride,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  input  logic [GAP_WIDTH-1:0]   cmd_gap,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_last,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_TWO = COUNT_WIDTH'(2);
  localparam logic [GAP_WIDTH-1:0]   GAP_ONE = GAP_WIDTH'(1);

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [DATA_WIDTH-1:0]  stride_q;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic [GAP_WIDTH-1:0]   gap_q;
  logic [GAP_WIDTH-1:0]   gap_cnt_q;
  logic                   valid_q;
  logic                   last_q;
  logic                   done_q;
  logic [COUNT_WIDTH-1:0] stall_q;
  logic [COUNT_WIDTH-1:0] stall_d;

  // Saturating stall counter: sticks at all-ones.
  assign stall_d = (stall_q == '1) ? stall_q : stall_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      stall_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            data_q      <= cmd_start;
            stride_q    <= cmd_stride;
            remaining_q <= cmd_count;
            gap_q       <= cmd_gap;
            stall_q     <= '0;
            if (cmd_count == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= SEND;
              valid_q <= 1'b1;
              last_q  <= (cmd_count == CNT_ONE);
            end
          end
        end
        SEND: begin
          if (o_ready) begin
            if (last_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              data_q      <= data_q + stride_q;
              remaining_q <= remaining_q - CNT_ONE;
              if (gap_q != '0) begin
                state_q   <= GAP;
                gap_cnt_q <= gap_q;
                valid_q   <= 1'b0;
                last_q    <= 1'b0;
              end else begin
                last_q <= (remaining_q == CNT_TWO);
              end
            end
          end else begin
            stall_q <= stall_d;
          end
        end
        GAP: begin
          // remaining_q was already decremented on the beat that entered GAP.
          if (gap_cnt_q == GAP_ONE) begin
            state_q <= SEND;
            valid_q <= 1'b1;
            last_q  <= (remaining_q == CNT_ONE);
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_last    = last_q;
  assign done      = done_q;
  assign stall_cnt = stall_q;

endmodule

// File: doc/stream_burst_source.md
# stream_burst_source

- Command-driven valid/ready stream transmitter: the producer end of the team's single-entry valid/ready stream buffer.
- Accepts a burst command (start value, stride, beat count, inter-beat gap) and emits an arithmetic data sequence on a valid/ready output, honouring backpressure.
- Flags the final beat of each burst and reports completion and stall statistics.
- Used as a traffic source in stream-buffer benches and as the producer stage feeding the stream buffer in the design.

## Interface

Parameters:
- DATA_WIDTH, 32, width of output data, start and stride
- COUNT_WIDTH, 16, width of beat count and counters
- GAP_WIDTH, 4, width of inter-beat gap field

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_start  input  DATA_WIDTH  first data value
- cmd_stride  input  DATA_WIDTH  increment between beats
- cmd_count  input  COUNT_WIDTH  number of beats, 0 allowed
- cmd_gap  input  GAP_WIDTH  idle cycles inserted after each non-final beat
- o_valid  output  1  output beat valid
- o_ready  input  1  downstream accepts beat
- o_data  output  DATA_WIDTH  beat data
- o_last  output  1  high with final beat of burst
- done  output  1  one-cycle pulse after burst completes
- stall_cnt  output  COUNT_WIDTH  cycles of o_valid && !o_ready in current/last burst, saturating

## Operation

- States: IDLE, SEND, GAP.
- IDLE:
  - cmd_ready=1, o_valid=0.
  - On cmd_valid: latch all fields, clear stall_cnt, set remaining=cmd_count.
  - If count==0: stay IDLE, pulse done next cycle.
  - Otherwise go SEND with o_data=cmd_start.
- SEND:
  - o_valid=1; o_last=1 iff remaining==1.
  - On o_valid && o_ready:
    - If last: go IDLE, pulse done.
    - Otherwise: data <= data + stride, remaining--, then go GAP if gap!=0, else stay SEND.
- GAP: o_valid=0; count down gap cycles, then return to SEND.
- Backpressure rule: once o_valid rises, o_valid, o_data and o_last hold stable until handshake. No combinational path from o_ready to o_valid or o_data.
- Arithmetic: data addition modulo 2^DATA_WIDTH (wrap, no saturation). stall_cnt saturates at all-ones.
- cmd_ready=0 in SEND and GAP. Commands are not queued.
- o_ready ignored when o_valid=0.

## Timing

- Reset values: cmd_ready=1 after reset; o_valid=0, o_data=0, o_last=0, done=0, stall_cnt=0, state IDLE.
- Command accept to first o_valid: 1 cycle.
- With gap=0 and o_ready held high: one beat per cycle, N beats in N cycles.
- With gap=g: beats spaced g+1 cycles apart absent stalls.
- done:
  - Asserted the cycle after the last handshake (or the cycle after a count==0 accept), for exactly 1 cycle.
  - cmd_ready is already 1 in that cycle, so a new command may be accepted while done is high.
- Reset mid-burst: next cycle matches reset values; the burst is abandoned and done is not pulsed.
- count==max (all ones): full count emitted, no overflow of remaining.

## Test plan

- Basic burst:
  - Stimulus: start=0x10, stride=4, count=4, gap=0, o_ready=1.
  - Response: data 0x10,0x14,0x18,0x1C on 4 consecutive cycles; o_last on 0x1C only; done 1 cycle later; stall_cnt=0.
- Backpressure:
  - Stimulus: same command; o_ready low 3 cycles on beat 2.
  - Response: 0x14 held stable with o_valid high for all 3 cycles; stall_cnt=3; sequence unchanged.
- Gap insertion:
  - Stimulus: count=3, gap=2, o_ready=1.
  - Response: beats at cycles 1, 4, 7 after accept; o_valid low in between.
- Wrap and zero count:
  - Stimulus 1: DATA_WIDTH=32, start=0xFFFFFFFE, stride=1, count=3.
  - Response 1: data 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
  - Stimulus 2: count=0 command.
  - Response 2: no o_valid; done 1 cycle after accept.
- Back-to-back commands:
  - Stimulus: second command held on cmd_valid during the first burst.
  - Response: cmd_ready low until the burst ends; second command accepted in the done cycle.
- Reset mid-burst:
  - Stimulus: rst asserted after beat 2 of a count=8 burst.
  - Response: o_valid=0 next cycle, no done pulse, cmd_ready=1.
